// File: rtl/test_counter.sv
`default_nettype none
// ============================================================================
// Module      : test_counter
// Description : Nine-digit synchronous BCD up-counter (000,000,000..999,999,999)
//               with per-digit rollover-pending flags. Clock on io_in[0],
//               synchronous active-high reset on io_in[1]. Defining
//               COUNT_ENABLE_EN turns io_in[2] into an active-high count enable.
// Revision    : 1.0 - initial release
// ============================================================================
module test_counter (
    input  logic [7:0] io_in,
    output logic [4:0] ones,
    output logic [4:0] tens,
    output logic [4:0] hund,
    output logic [4:0] thou,
    output logic [4:0] tenT,
    output logic [4:0] hunT,
    output logic [4:0] mil,
    output logic [4:0] tenM,
    output logic [4:0] hunM
);
    localparam int unsigned c_DIGITS = 9;

    logic clk;
    logic rst;
    logic w_count_en;
    logic w_unused_bits;

    // Digit k occupies r_digits_q[4k+3:4k]; ones is the least significant nibble.
    logic [4*c_DIGITS-1:0] r_digits_q;
    logic [4*c_DIGITS-1:0] r_digits_d;

    // w_all9[k] is set when digits 0..k-1 are all 9 (w_all9[0] is trivially true).
    logic [c_DIGITS:0] w_all9;

    assign clk = io_in[0];
    assign rst = io_in[1];

`ifdef COUNT_ENABLE_EN
    assign w_count_en    = io_in[2];
    assign w_unused_bits = ^io_in[7:3];
`else
    assign w_count_en    = 1'b1;
    assign w_unused_bits = ^io_in[7:2];
`endif

    assign w_all9[0] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < c_DIGITS; k++) begin : g_digit
            logic [3:0] w_digit;
            logic       w_nine;

            assign w_digit     = r_digits_q[4*k +: 4];
            assign w_nine      = (w_digit == 4'd9);
            assign w_all9[k+1] = w_all9[k] & w_nine;

            // A digit advances only when every lower digit is about to wrap.
            assign r_digits_d[4*k +: 4] = (w_count_en && w_all9[k])
                                        ? (w_nine ? 4'd0 : w_digit + 4'd1)
                                        : w_digit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits_q <= '0;
        end else begin
            r_digits_q <= r_digits_d;
        end
    end

    // Flag bit k equals w_all9[k+1]: this digit and all below it are 9.
    assign ones = {w_all9[1], r_digits_q[3:0]};
    assign tens = {w_all9[2], r_digits_q[7:4]};
    assign hund = {w_all9[3], r_digits_q[11:8]};
    assign thou = {w_all9[4], r_digits_q[15:12]};
    assign tenT = {w_all9[5], r_digits_q[19:16]};
    assign hunT = {w_all9[6], r_digits_q[23:20]};
    assign mil  = {w_all9[7], r_digits_q[27:24]};
    assign tenM = {w_all9[8], r_digits_q[31:28]};
    assign hunM = {w_all9[9], r_digits_q[35:32]};

endmodule
`default_nettype wire

// File: tb/tb_test_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_counter
// Description : Self-checking bench for test_counter: directed vector table,
//               preload/wrap sequence, enable sequence and randomized run
//               against an arithmetic model of the decimal count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] spare;
    logic [7:0] io_in;

    logic [4:0] ones, tens, hund, thou, tenT, hunT, mil, tenM, hunM;

    int checks;
    int errors;
    longint unsigned m_count;

    assign io_in = {spare, en, rst, clk};

    test_counter dut (
        .io_in (io_in),
        .ones  (ones),
        .tens  (tens),
        .hund  (hund),
        .thou  (thou),
        .tenT  (tenT),
        .hunT  (hunT),
        .mil   (mil),
        .tenM  (tenM),
        .hunM  (hunM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        bit              rst;
        int              edges;
        longint unsigned exp_val;
    } vec_t;

    // Expected bus {hunM..ones} derived from the decimal value by plain arithmetic.
    function automatic logic [44:0] exp_out(longint unsigned v);
        logic [44:0]     r;
        longint unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < 9; k++) begin
            r[5*k +: 4] = 4'((v / p) % 10);
            r[5*k + 4]  = ((v % (p * 10)) == (p * 10 - 1));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic longint unsigned model_next(longint unsigned c, bit r, bit e);
        bit eff;
`ifdef COUNT_ENABLE_EN
        eff = e;
`else
        eff = 1'b1;
`endif
        if (r) return 0;
        if (!eff) return c;
        return (c + 1) % 64'd1000000000;
    endfunction

    task automatic check(input string name, input longint unsigned v);
        logic [44:0] got;
        logic [44:0] want;
        got  = {hunM, tenM, mil, hunT, tenT, thou, hund, tens, ones};
        want = exp_out(v);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h (value %0d)", name, got, want, v);
        end
    endtask

    // One rising edge with the current rst/en, model tracking, sample on falling edge.
    task automatic tick();
        spare = 5'($urandom);
        @(posedge clk);
        m_count = model_next(m_count, rst, en);
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        checks  = 0;
        errors  = 0;
        m_count = 0;
        rst     = 1'b1;
        en      = 1'b1;
        spare   = '0;

        vecs.push_back('{"reset",          1'b1,   2,    0});
        vecs.push_back('{"count_9",        1'b0,   9,    9});
        vecs.push_back('{"count_10",       1'b0,   1,   10});
        vecs.push_back('{"count_999",      1'b0, 989,  999});
        vecs.push_back('{"count_1000",     1'b0,   1, 1000});
        vecs.push_back('{"reset_mid",      1'b1,   1,    0});
        vecs.push_back('{"count_37",       1'b0,  37,   37});
        vecs.push_back('{"reset_at_37",    1'b1,   1,    0});
        vecs.push_back('{"resume_1",       1'b0,   1,    1});

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            en  = 1'b1;
            for (int e = 0; e < vecs[i].edges; e++) tick();
            check(vecs[i].name, vecs[i].exp_val);
        end

        // Preload just below full scale, then walk through the wrap.
        force dut.r_digits_q = 36'h999999998;
        #1;
        release dut.r_digits_q;
        m_count = 64'd999999998;
        rst = 1'b0;
        en  = 1'b1;
        check("preload_998", m_count);
        tick();
        check("all_nines", m_count);
        tick();
        check("wrap_to_zero", m_count);
        tick();
        check("after_wrap", m_count);

        // Enable low for five edges, then resume.
        for (int e = 0; e < 12; e++) tick();
        en = 1'b0;
        for (int e = 0; e < 5; e++) tick();
        check("enable_low_hold", m_count);
        en = 1'b1;
        tick();
        check("enable_resume", m_count);

        // Randomized run, occasionally jumping near a carry boundary.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                force dut.r_digits_q = 36'h099999990;
                #1;
                release dut.r_digits_q;
                m_count = 64'd99999990;
            end
            rst = ($urandom_range(0, 29) == 0);
            en  = ($urandom_range(0, 3) != 0);
            tick();
            check("random", m_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
